// File: rtl/serial_addsub.sv
// Digit-serial ripple-carry adder/subtractor: resolves DIGIT bits of a WIDTH-bit
// operand pair per clock, LSB digit first, under a start/busy/done handshake.
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    // One digit of the ripple chain; the carry into the digit's top bit is kept
    // because on the last digit that bit is the sign bit and feeds the overflow flag.
    logic [DIGIT-1:0] dig_a, dig_b, dig_sum;
    logic             dig_c, dig_c_top_in;
    int               base;

    always_comb begin
        base         = int'(cnt_q) * DIGIT;
        dig_a        = opa_q[base +: DIGIT];
        dig_b        = opb_q[base +: DIGIT];
        dig_sum      = '0;
        dig_c        = carry_q;
        dig_c_top_in = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) dig_c_top_in = dig_c;
            dig_sum[i] = dig_a[i] ^ dig_b[i] ^ dig_c;
            dig_c      = (dig_a[i] & dig_b[i]) | (dig_c & (dig_a[i] ^ dig_b[i]));
        end
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    opa_d   = a;
                    opb_d   = mode ? ~b : b;
                    carry_d = mode;
                    cnt_d   = '0;
                    y_d     = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                y_d[base +: DIGIT] = dig_sum;
                carry_d            = dig_c;
                cnt_d              = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cout_d  = dig_c;
                    ovf_d   = dig_c_top_in ^ dig_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign y    = y_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: four configurations share one stimulus stream and are
// compared against an arithmetic reference model.
module tb_serial_addsub;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode  = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;

    always #5 clk = ~clk;

    localparam int NI = 4;
    int widths [NI] = '{16, 16, 16, 32};
    int digits [NI] = '{4, 1, 16, 8};

    logic [NI-1:0] busy_v, done_v, cout_v, ovf_v;
    logic [15:0]   y0, y1, y2;
    logic [31:0]   y3;
    logic [31:0]   y_v [NI];

    assign y_v[0] = {16'h0, y0};
    assign y_v[1] = {16'h0, y1};
    assign y_v[2] = {16'h0, y2};
    assign y_v[3] = y3;

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a[15:0]), .b(b[15:0]),
        .busy(busy_v[0]), .done(done_v[0]), .y(y0), .cout(cout_v[0]), .ovf(ovf_v[0]));
    serial_addsub #(.WIDTH(16), .DIGIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a[15:0]), .b(b[15:0]),
        .busy(busy_v[1]), .done(done_v[1]), .y(y1), .cout(cout_v[1]), .ovf(ovf_v[1]));
    serial_addsub #(.WIDTH(16), .DIGIT(16)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a[15:0]), .b(b[15:0]),
        .busy(busy_v[2]), .done(done_v[2]), .y(y2), .cout(cout_v[2]), .ovf(ovf_v[2]));
    serial_addsub #(.WIDTH(32), .DIGIT(8)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy_v[3]), .done(done_v[3]), .y(y3), .cout(cout_v[3]), .ovf(ovf_v[3]));

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] y;
        logic        c;
        logic        o;
    } res_t;

    // Plain unsigned/signed arithmetic on w-bit values.
    function automatic res_t model(int w, logic [31:0] oa, logic [31:0] ob, logic m);
        res_t            r;
        longint unsigned mask, aa, bb, s;
        logic            sa, sb, sy;
        mask = (64'd1 << w) - 64'd1;
        aa   = 64'(oa) & mask;
        bb   = 64'(ob) & mask;
        s    = m ? (aa - bb) : (aa + bb);
        r.y  = 32'(s & mask);
        r.c  = m ? (aa >= bb) : ((aa + bb) > mask);
        sa   = aa[w-1];
        sb   = bb[w-1];
        sy   = s[w-1];
        r.o  = m ? ((sa != sb) && (sy != sa)) : ((sa == sb) && (sy != sa));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation on all instances and check result, flags, latency,
    // done width, busy duration and result hold.
    task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic m,
                          input string tag);
        int          lat [NI];
        int          dcnt [NI];
        int          bcnt [NI];
        logic [31:0] ry [NI];
        logic        rc [NI];
        logic        ro [NI];
        res_t        e;
        a = oa; b = ob; mode = m; start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom; mode = 1'($urandom_range(0, 1));
        for (int i = 0; i < NI; i++) begin
            lat[i] = 0; dcnt[i] = 0; ry[i] = '0; rc[i] = 1'b0; ro[i] = 1'b0;
            bcnt[i] = int'(busy_v[i]);
        end
        for (int k = 1; k <= 17; k++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                if (busy_v[i]) bcnt[i]++;
                if (done_v[i]) begin
                    dcnt[i]++;
                    if (lat[i] == 0) begin
                        lat[i] = k; ry[i] = y_v[i]; rc[i] = cout_v[i]; ro[i] = ovf_v[i];
                    end
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            e = model(widths[i], oa, ob, m);
            check($sformatf("%s/u%0d.y", tag, i), ry[i], e.y);
            check($sformatf("%s/u%0d.cout", tag, i), 32'(rc[i]), 32'(e.c));
            check($sformatf("%s/u%0d.ovf", tag, i), 32'(ro[i]), 32'(e.o));
            check($sformatf("%s/u%0d.latency", tag, i), 32'(lat[i]), 32'(widths[i] / digits[i]));
            check($sformatf("%s/u%0d.done_cycles", tag, i), 32'(dcnt[i]), 32'd1);
            check($sformatf("%s/u%0d.busy_cycles", tag, i), 32'(bcnt[i]), 32'(widths[i] / digits[i]));
            check($sformatf("%s/u%0d.y_hold", tag, i), y_v[i], e.y);
        end
    endtask

    task automatic wait_done0(input int budget, output int cycles);
        cycles = 0;
        while (!done_v[0] && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        #2;
        check("reset.busy", 32'(busy_v), 32'h0);
        check("reset.done", 32'(done_v), 32'h0);
        check("reset.y", y_v[0] | y_v[1] | y_v[2] | y_v[3], 32'h0);
        check("reset.flags", 32'({cout_v, ovf_v}), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        run_op(32'h1234, 32'h0FFF, 1'b0, "add_basic");
        run_op(32'h7FFF, 32'h0001, 1'b0, "add_ovf");
        run_op(32'hFFFF, 32'h0001, 1'b0, "add_carry");
        run_op(32'h0000, 32'h0001, 1'b1, "sub_borrow");
        run_op(32'h8000, 32'h0001, 1'b1, "sub_ovf");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, "sub_ovf32");

        // start during RUN must not disturb the in-flight operation (u0 only).
        a = 32'h1111; b = 32'h2222; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 32'hFFFF; b = 32'h0F0F; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done0(10, cyc);
        check("ignore.latency", 32'(cyc + 2), 32'd4);
        check("ignore.y", y_v[0], 32'h3333);
        check("ignore.done", 32'(done_v[0]), 32'd1);
        repeat (20) tick();

        // Back-to-back: start in the done cycle is accepted (u0 only).
        a = 32'h0101; b = 32'h0202; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done0(10, cyc);
        check("b2b.first_latency", 32'(cyc), 32'd4);
        check("b2b.first_y", y_v[0], 32'h0303);
        a = 32'h0005; b = 32'h0003; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b.busy", 32'(busy_v[0]), 32'd1);
        check("b2b.done_low", 32'(done_v[0]), 32'd0);
        check("b2b.y_cleared", y_v[0], 32'h0);
        repeat (3) tick();
        check("b2b.not_early", 32'(done_v[0]), 32'd0);
        tick();
        check("b2b.done", 32'(done_v[0]), 32'd1);
        check("b2b.y", y_v[0], 32'h0002);
        check("b2b.cout", 32'(cout_v[0]), 32'd1);
        check("b2b.ovf", 32'(ovf_v[0]), 32'd0);
        repeat (20) tick();

        // Reset during RUN aborts immediately with no done pulse.
        a = 32'h1234; b = 32'h1111; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(busy_v), 32'h0);
        check("abort.y", y_v[0] | y_v[1] | y_v[2] | y_v[3], 32'h0);
        check("abort.flags", 32'({cout_v, ovf_v, done_v}), 32'h0);
        cyc = 0;
        repeat (3) begin
            tick();
            if (done_v != '0) cyc++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            tick();
            if (done_v != '0) cyc++;
        end
        check("abort.no_done", 32'(cyc), 32'd0);
        run_op(32'hA5A5, 32'h5A5A, 1'b1, "after_reset");

        for (int n = 0; n < 200; n++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
